// File: rtl/qsys_lights_out_if.sv
// Avalon-MM slave bus bundle for the lamp output port.
// The master drives address/strobes/data; the slave returns registered readdata.
interface qsys_lights_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/qsys_lights_out.sv
// Lamp output port: set/clear data register, hardware blink generator
// toggling masked bits at a programmable half-period, and a tick interrupt.
module qsys_lights_out #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  qsys_lights_out_if.slave bus,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RST_DATA = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0]       data_reg,   data_next;
  logic [WIDTH-1:0]       mask_reg,   mask_next;
  logic [COUNT_WIDTH-1:0] period_reg, period_next;
  logic [COUNT_WIDTH-1:0] count_reg,  count_next;
  logic                   phase_reg,  phase_next;
  logic                   tick_reg,   tick_next;
  logic                   irq_en_reg, irq_en_next;
  logic [31:0]            readdata_reg, readdata_next;
  logic [WIDTH-1:0]       out_reg,    out_next;

  logic wr;
  logic wr_data, wr_mask, wr_period, wr_status, wr_set, wr_clr;
  logic tick_set;
  logic [31:0] data_ext, mask_ext, period_ext, count_ext;
  logic unused_bits;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_data   = wr && (bus.address == 3'd0);
  assign wr_mask   = wr && (bus.address == 3'd1);
  assign wr_period = wr && (bus.address == 3'd2);
  assign wr_status = wr && (bus.address == 3'd3);
  assign wr_set    = wr && (bus.address == 3'd4);
  assign wr_clr    = wr && (bus.address == 3'd5);

  assign unused_bits = ^bus.writedata;

  always_comb begin
    data_next   = data_reg;
    mask_next   = mask_reg;
    period_next = period_reg;
    irq_en_next = irq_en_reg;
    if (wr_data)
      data_next = bus.writedata[WIDTH-1:0];
    else if (wr_set)
      data_next = data_reg | bus.writedata[WIDTH-1:0];
    else if (wr_clr)
      data_next = data_reg & ~bus.writedata[WIDTH-1:0];
    if (wr_mask)
      mask_next = bus.writedata[WIDTH-1:0];
    if (wr_period)
      period_next = bus.writedata[COUNT_WIDTH-1:0];
    if (wr_status)
      irq_en_next = bus.writedata[1];
  end

  // A PERIOD write restarts the blink cleanly and suppresses any wrap on that edge.
  always_comb begin
    count_next = count_reg;
    phase_next = phase_reg;
    tick_set   = 1'b0;
    if (wr_period) begin
      count_next = '0;
      phase_next = 1'b0;
    end else if (period_reg == '0) begin
      count_next = '0;
      phase_next = 1'b0;
    end else if (count_reg == period_reg - COUNT_WIDTH'(1)) begin
      count_next = '0;
      phase_next = ~phase_reg;
      tick_set   = 1'b1;
    end else begin
      count_next = count_reg + COUNT_WIDTH'(1);
    end
    tick_next = tick_set | (tick_reg & ~wr_status);
  end

  always_comb begin
    data_ext   = '0;
    mask_ext   = '0;
    period_ext = '0;
    count_ext  = '0;
    data_ext[WIDTH-1:0]         = data_reg;
    mask_ext[WIDTH-1:0]         = mask_reg;
    period_ext[COUNT_WIDTH-1:0] = period_reg;
    count_ext[COUNT_WIDTH-1:0]  = count_reg;
  end

  always_comb begin
    readdata_next = '0;
    case (bus.address)
      3'd0:    readdata_next = data_ext;
      3'd1:    readdata_next = mask_ext;
      3'd2:    readdata_next = period_ext;
      3'd3:    readdata_next = {29'b0, phase_reg, irq_en_reg, tick_reg};
      3'd6:    readdata_next = count_ext;
      default: readdata_next = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_out
      assign out_next[gi] = data_reg[gi] ^ (mask_reg[gi] & phase_reg);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg     <= RST_DATA;
      mask_reg     <= '0;
      period_reg   <= '0;
      count_reg    <= '0;
      phase_reg    <= 1'b0;
      tick_reg     <= 1'b0;
      irq_en_reg   <= 1'b0;
      readdata_reg <= '0;
      out_reg      <= RST_DATA;
    end else begin
      data_reg     <= data_next;
      mask_reg     <= mask_next;
      period_reg   <= period_next;
      count_reg    <= count_next;
      phase_reg    <= phase_next;
      tick_reg     <= tick_next;
      irq_en_reg   <= irq_en_next;
      readdata_reg <= readdata_next;
      out_reg      <= out_next;
    end
  end

  assign bus.readdata = readdata_reg;
  assign out_port     = out_reg;
  assign irq          = tick_reg & irq_en_reg;

endmodule

// File: tb/tb_qsys_lights_out.sv
// Testbench for qsys_lights_out: register table, then hand-timed blink,
// interrupt, collision, period-rewrite and asynchronous-reset sequences.
module tb_qsys_lights_out;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] out_port;
  logic       irq;

  qsys_lights_out_if bus ();

  qsys_lights_out #(
    .WIDTH       (8),
    .RESET_VALUE (32'h0000_00A5),
    .COUNT_WIDTH (32)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    bit          is_wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[17];

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic pop_check();
    sb_t s;
    if (sbq.size() == 0) begin
      nchk++;
      nerr++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      s = sbq.pop_front();
      chk(s.name, bus.readdata, s.exp);
    end
  endtask

  task automatic idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd7;
    bus.writedata  = '0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    $display("write addr=%0d data=%h", a, d);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    sb_t s;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    bus.writedata  = '0;
    s.name = name;
    s.exp  = exp;
    sbq.push_back(s);
    @(negedge clk);
    bus.chipselect = 1'b0;
    pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 3'd1, 32'h0000_005A, 32'h0};
    vecs[1]  = '{1'b0, 3'd1, 32'h0,         32'h0000_005A};
    vecs[2]  = '{1'b1, 3'd0, 32'h1234_5666, 32'h0};
    vecs[3]  = '{1'b0, 3'd0, 32'h0,         32'h0000_0066};
    vecs[4]  = '{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{1'b0, 3'd3, 32'h0,         32'h0000_0002};
    vecs[6]  = '{1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0};
    vecs[7]  = '{1'b0, 3'd2, 32'h0,         32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 3'd2, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, 3'd6, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{1'b0, 3'd6, 32'h0,         32'h0};
    vecs[12] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0};
    vecs[13] = '{1'b0, 3'd7, 32'h0,         32'h0};
    vecs[14] = '{1'b0, 3'd0, 32'h0,         32'h0000_0066};
    vecs[15] = '{1'b1, 3'd3, 32'h0,         32'h0};
    vecs[16] = '{1'b0, 3'd3, 32'h0,         32'h0};

    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = '0;

    // reset held low
    @(negedge clk);
    @(negedge clk);
    chk("reset out_port", {24'h0, out_port}, 32'h0000_00A5);
    chk("reset readdata", bus.readdata, 32'h0);
    chk("reset irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    rd("reset DATA", 3'd0, 32'h0000_00A5);

    // set / clear
    wr(3'd0, 32'h0000_000F);
    wr(3'd4, 32'h0000_00F0);
    wr(3'd5, 32'h0000_003C);
    chk("setclr out_port before", {24'h0, out_port}, 32'h0000_00FF);
    idle();
    chk("setclr out_port after", {24'h0, out_port}, 32'h0000_00C3);
    rd("setclr DATA", 3'd0, 32'h0000_00C3);
    rd("OUTSET reads 0", 3'd4, 32'h0);
    rd("OUTCLEAR reads 0", 3'd5, 32'h0);

    // register table
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].is_wr)
        wr(vecs[i].addr, vecs[i].data);
      else
        rd($sformatf("table[%0d] addr %0d", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end
    chk("table out_port", {24'h0, out_port}, 32'h0000_0066);

    // blink with PERIOD=4
    wr(3'd0, 32'h0000_0001);
    wr(3'd1, 32'h0000_0081);
    wr(3'd2, 32'h0000_0004);
    for (int k = 1; k <= 16; k++) begin
      rd($sformatf("blink COUNT k=%0d", k), 3'd6, 32'((k - 1) % 4));
      chk($sformatf("blink out_port k=%0d", k), {24'h0, out_port},
          ((((k - 1) / 4) % 2) == 1) ? 32'h0000_0080 : 32'h0000_0001);
    end
    wr(3'd2, 32'h0);
    idle();
    idle();
    chk("blink off out_port", {24'h0, out_port}, 32'h0000_0001);
    rd("blink off STATUS", 3'd3, 32'h0000_0001);
    rd("blink off COUNT", 3'd6, 32'h0);

    // interrupt with PERIOD=3
    wr(3'd3, 32'h0000_0002);
    wr(3'd2, 32'h0000_0003);
    idle();
    chk("irq P+1", {31'h0, irq}, 32'h0);
    idle();
    chk("irq P+2", {31'h0, irq}, 32'h0);
    idle();
    chk("irq P+3", {31'h0, irq}, 32'h1);
    wr(3'd3, 32'h0000_0002);
    chk("irq cleared", {31'h0, irq}, 32'h0);
    wr(3'd3, 32'h0);
    idle();
    chk("irq masked", {31'h0, irq}, 32'h0);
    rd("masked STATUS", 3'd3, 32'h0000_0001);

    // PERIOD write on a wrap edge suppresses the tick; STATUS clear on a wrap keeps it
    wr(3'd3, 32'h0000_0002);
    wr(3'd2, 32'h0000_0003);
    chk("period write no tick", {31'h0, irq}, 32'h0);
    idle();
    idle();
    wr(3'd3, 32'h0000_0002);
    chk("collision irq", {31'h0, irq}, 32'h1);
    rd("collision STATUS", 3'd3, 32'h0000_0007);
    chk("collision irq held", {31'h0, irq}, 32'h1);
    wr(3'd3, 32'h0000_0002);
    chk("collision later clear", {31'h0, irq}, 32'h0);

    // period rewrite mid-count
    wr(3'd2, 32'd10);
    for (int k = 0; k < 10; k++) idle();
    wr(3'd3, 32'h0000_0002);
    idle();
    idle();
    rd("rewrite pre STATUS", 3'd3, 32'h0000_0006);
    rd("rewrite pre COUNT", 3'd6, 32'd4);
    wr(3'd2, 32'd6);
    rd("rewrite COUNT", 3'd6, 32'd0);
    rd("rewrite STATUS", 3'd3, 32'h0000_0002);
    idle();
    idle();
    idle();
    chk("rewrite irq before", {31'h0, irq}, 32'h0);
    idle();
    chk("rewrite irq toggle", {31'h0, irq}, 32'h1);
    rd("rewrite post STATUS", 3'd3, 32'h0000_0007);

    // asynchronous reset mid-blink
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset out_port", {24'h0, out_port}, 32'h0000_00A5);
    chk("async reset readdata", bus.readdata, 32'h0);
    chk("async reset irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd("post reset DATA", 3'd0, 32'h0000_00A5);
    rd("post reset PERIOD", 3'd2, 32'h0);
    rd("post reset MASK", 3'd1, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/qsys_lights_out.md
# qsys_lights_out

Avalon-MM output-port slave that drives the traffic-light lamps. It is the write-side counterpart of the key input port on the same Qsys bus. It holds a software-written output register with atomic set/clear access. A hardware blink generator toggles selected bits at a programmable half-period without CPU involvement and raises a maskable interrupt on every blink phase change.

## Interface
Parameters:
- WIDTH, 8, number of output bits on out_port (1..32)
- RESET_VALUE, 0, value loaded into the data register on reset
- COUNT_WIDTH, 32, width of the period register and the blink counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- address  input  3  register select (word address)
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe, qualified by chipselect
- writedata  input  32  write data
- readdata  output  32  registered read data
- out_port  output  WIDTH  lamp drive outputs, registered
- irq  output  1  interrupt request, level, active-high

## Operation
- Register map (wr = chipselect & ~write_n & address match):
  - 0 DATA, R/W, WIDTH bits.
  - 1 BLINK_MASK, R/W, WIDTH bits.
  - 2 PERIOD, R/W, COUNT_WIDTH bits; blink half-period in clocks.
  - 3 STATUS, bit0 TICK, bit1 IRQ_EN, bit2 PHASE (read-only). Any write clears TICK; writedata[1] loads IRQ_EN.
  - 4 OUTSET, write-only: DATA <= DATA | writedata[WIDTH-1:0]. Reads 0.
  - 5 OUTCLEAR, write-only: DATA <= DATA & ~writedata[WIDTH-1:0]. Reads 0.
  - 6 COUNT, read-only, current counter value.
  - 7 reserved: reads 0, writes ignored.
- Unused upper readdata bits read 0. Writes to read-only or unused bits are ignored.
- Blink generator:
  - PERIOD == 0: blink disabled; counter and PHASE held at 0.
  - PERIOD != 0: counter increments each clock. When counter == PERIOD-1, the counter returns to 0, PHASE toggles and TICK sets.
  - A write to PERIOD forces counter <= 0 and PHASE <= 0 on the same edge, with no TICK on that edge.
- out_port <= DATA ^ (BLINK_MASK & {WIDTH{PHASE}}), registered from the current register values.
- irq = TICK & IRQ_EN, combinational from registers.
- Simultaneous TICK set and STATUS write on one edge: set wins and TICK ends at 1, so no event is lost. IRQ_EN still takes writedata[1].
- The counter compares with the full COUNT_WIDTH width and has no overflow path; wrap happens only at PERIOD-1.

## Timing
- Reset (async assert, sync to clk on deassert) sets:
  - DATA=RESET_VALUE, BLINK_MASK=0, PERIOD=0, counter=0, PHASE=0, TICK=0, IRQ_EN=0.
  - readdata=0, out_port=RESET_VALUE[WIDTH-1:0], irq=0.
- Reset asserted mid-blink aborts immediately. out_port takes RESET_VALUE asynchronously.
- Writes: single cycle, zero wait states. A register updates on the edge where wr is sampled.
- out_port reflects a register write one clock after that edge, i.e. 2 edges from write issue to pin.
- Reads: readdata is registered every clock from the addressed register (chipselect not required), giving 1-cycle read latency. Read has no side effects.
- PHASE toggles once every PERIOD clocks, so a full blink cycle is 2*PERIOD clocks. PERIOD=1 toggles every clock.
- irq asserts the edge TICK sets and deasserts the edge after a STATUS write that clears it, unless a new tick coincides.

## Test plan
- Reset: hold reset_n low with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata=0, irq=0. Release, read DATA -> 8'hA5 one cycle after the address.
- Set/clear: write DATA=8'h0F, OUTSET 8'hF0, OUTCLEAR 8'h3C -> DATA reads 8'hC3. out_port=8'hC3 one clock after the last write. OUTSET reads 0.
- Blink: DATA=8'h01, BLINK_MASK=8'h81, PERIOD=4 -> out_port alternates 8'h01 / 8'h80 every 4 clocks. COUNT cycles 0..3. PERIOD=0 -> out_port steady 8'h01, PHASE=0.
- IRQ: PERIOD=3, STATUS=2 (IRQ_EN) -> irq rises 3 clocks after the PERIOD write. STATUS write 2 clears irq next edge. IRQ_EN=0 keeps irq low while TICK still reads 1.
- Collision: issue the STATUS clear write on the exact edge the counter wraps -> TICK reads 1 and irq stays high.
- Period rewrite: mid-count (COUNT=5, PERIOD=10, PHASE=1), write PERIOD=6 -> COUNT=0, PHASE=0 next cycle, no TICK. The next toggle comes 6 clocks later.
